// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained round-robin onto three registered lanes.
// Optional CDB_STATS_EN adds broadcast and stall counters.
module cdb_arbiter #(
  parameter int N_SRC = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N_SRC-1:0]     src_valid,
  output logic [N_SRC-1:0]     src_ready,
  input  logic [32*N_SRC-1:0]  src_data,
  input  logic [8*N_SRC-1:0]   src_tag,
  output logic [95:0]          CDB_data_serialized,
  output logic [23:0]          CDB_tag_serialized
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]          bcast_count,
  output logic [31:0]          stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(N_SRC);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [39:0]      mem_q    [N_SRC][DEPTH];
  logic [AW-1:0]    wr_ptr_q [N_SRC];
  logic [AW-1:0]    rd_ptr_q [N_SRC];
  logic [CW-1:0]    cnt_q    [N_SRC];
  logic [CW-1:0]    cnt_d    [N_SRC];
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0] push, pop, nonempty;
  logic [31:0]      lane_data_q [3];
  logic [31:0]      lane_data_d [3];
  logic [7:0]       lane_tag_q  [3];
  logic [7:0]       lane_tag_d  [3];
  int               pos  [N_SRC];
  int               rank [N_SRC];
  int               last_src, last_pos;

  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      src_ready[k] = (cnt_q[k] != FULL);
    end
  end

  // Tag 0 is the idle marker, so such results are accepted but never stored.
  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      nonempty[k] = (cnt_q[k] != '0);
      push[k]     = src_valid[k] && src_ready[k] && (src_tag[8*k +: 8] != 8'd0);
    end
  end

  // Grant by rank: a non-empty source's lane is the number of non-empty
  // sources ahead of it in the scan starting at rr_ptr.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    pop      = '0;
    last_src = -1;
    last_pos = -1;
    for (int k = 0; k < N_SRC; k++) begin
      pos[k] = k - int'(rr_ptr_q);
      if (pos[k] < 0) pos[k] = pos[k] + N_SRC;
    end
    for (int k = 0; k < N_SRC; k++) begin
      rank[k] = 0;
      for (int j = 0; j < N_SRC; j++) begin
        if (nonempty[j] && (pos[j] < pos[k])) rank[k] = rank[k] + 1;
      end
    end
    for (int k = 0; k < N_SRC; k++) begin
      pop[k] = en && nonempty[k] && (rank[k] < 3);
      if (pop[k] && (pos[k] > last_pos)) begin
        last_pos = pos[k];
        last_src = k;
      end
    end
    if (last_src >= 0) begin
      rr_ptr_d = (last_src == N_SRC - 1) ? '0 : PW'(last_src + 1);
    end
  end

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      lane_data_d[l] = '0;
      lane_tag_d[l]  = '0;
      for (int k = 0; k < N_SRC; k++) begin
        if (pop[k] && (rank[k] == l)) begin
          lane_data_d[l] = mem_q[k][rd_ptr_q[k]][39:8];
          lane_tag_d[l]  = mem_q[k][rd_ptr_q[k]][7:0];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
        2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_SRC; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= {src_data[32*k +: 32], src_tag[8*k +: 8]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      rr_ptr_q <= '0;
      for (int l = 0; l < 3; l++) begin
        lane_data_q[l] <= '0;
        lane_tag_q[l]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
      end
      rr_ptr_q <= rr_ptr_d;
      for (int l = 0; l < 3; l++) begin
        lane_data_q[l] <= lane_data_d[l];
        lane_tag_q[l]  <= lane_tag_d[l];
      end
    end
  end

  assign CDB_data_serialized = {lane_data_q[0], lane_data_q[1], lane_data_q[2]};
  assign CDB_tag_serialized  = {lane_tag_q[0], lane_tag_q[1], lane_tag_q[2]};

`ifdef CDB_STATS_EN
  logic [1:0]  n_grant;
  logic [31:0] bcast_q, stall_q;

  always_comb begin
    n_grant = '0;
    for (int k = 0; k < N_SRC; k++) begin
      n_grant = n_grant + {1'b0, pop[k]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcast_q <= '0;
      stall_q <= '0;
    end else begin
      bcast_q <= bcast_q + 32'(n_grant);
      if (!en && (|nonempty)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bcast_count = bcast_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [127:0] src_data;
  logic [31:0]  src_tag;
  logic [95:0]  CDB_data_serialized;
  logic [23:0]  CDB_tag_serialized;
`ifdef CDB_STATS_EN
  logic [31:0]  bcast_count, stall_count;
`endif

  cdb_arbiter #(.N_SRC(N), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .en                  (en),
    .src_valid           (src_valid),
    .src_ready           (src_ready),
    .src_data            (src_data),
    .src_tag             (src_tag),
    .CDB_data_serialized (CDB_data_serialized),
    .CDB_tag_serialized  (CDB_tag_serialized)
`ifdef CDB_STATS_EN
    ,
    .bcast_count         (bcast_count),
    .stall_count         (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one queue of {data, tag} per source plus the scan pointer
  logic [39:0] mq [N][$];
  int          rr;
  logic [23:0] exp_tag;
  logic [95:0] exp_data;
  int          nt = 0;

  task automatic check(input string name, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) mq[k].delete();
    rr       = 0;
    exp_tag  = '0;
    exp_data = '0;
  endtask

  // One cycle: check outputs at the negedge, drive new inputs, advance the model.
  task automatic step(input logic e, input logic [3:0] v, input logic [127:0] d, input logic [31:0] t);
    logic [3:0]  rdy;
    logic [39:0] h;
    int          g, last, s;
    @(negedge clk);
    for (int k = 0; k < N; k++) rdy[k] = (mq[k].size() < DEPTH);
    check("src_ready", 96'(src_ready), 96'(rdy));
    check("cdb_tag", 96'(CDB_tag_serialized), 96'(exp_tag));
    check("cdb_data", CDB_data_serialized, exp_data);
    en        = e;
    src_valid = v;
    src_data  = d;
    src_tag   = t;
    exp_tag   = '0;
    exp_data  = '0;
    g         = 0;
    last      = -1;
    if (e) begin
      for (int i = 0; i < N; i++) begin
        s = (rr + i) % N;
        if (mq[s].size() > 0 && g < 3) begin
          h = mq[s].pop_front();
          exp_data[95-32*g -: 32] = h[39:8];
          exp_tag[23-8*g -: 8]    = h[7:0];
          g++;
          last = s;
        end
      end
    end
    if (g > 0) rr = (last + 1) % N;
    for (int k = 0; k < N; k++) begin
      if (v[k] && rdy[k] && t[8*k +: 8] != 8'd0) mq[k].push_back({d[32*k +: 32], t[8*k +: 8]});
    end
  endtask

  task automatic next_tag(output logic [7:0] tg);
    nt = (nt >= 255) ? 1 : nt + 1;
    tg = 8'(nt);
  endtask

  task automatic rand_inputs(output logic [127:0] d, output logic [31:0] t);
    logic [7:0] tg;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < N; k++) begin
      next_tag(tg);
      t[8*k +: 8] = ($urandom_range(0, 9) == 0) ? 8'd0 : tg;
    end
  endtask

  logic [127:0] rd;
  logic [31:0]  rt;
  logic [127:0] d29;

  initial begin
    model_reset();
    reset     = 1'b0;
    en        = 1'b0;
    src_valid = 4'hF;
    src_data  = '0;
    src_tag   = 32'h01020304;
    d29       = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // held in reset with all sources valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 96'(src_ready), 96'hF);
      check("rst_tag", 96'(CDB_tag_serialized), 96'd0);
    end
    @(negedge clk);
    src_valid = 4'h0;
    reset     = 1'b1;
    step(1'b1, 4'h0, '0, '0);
    step(1'b1, 4'h0, '0, '0);

    // four sources, one result each
    step(1'b1, 4'hF, d29, 32'h44332211);
    step(1'b1, 4'h0, '0, '0);
    @(posedge clk); #1;
    check("lanes_first", 96'(CDB_tag_serialized), 96'h112233);
    check("lane0_data", 96'(CDB_data_serialized[95:64]), 96'hA0);
    step(1'b1, 4'h0, '0, '0);
    @(posedge clk); #1;
    check("lanes_second", 96'(CDB_tag_serialized), 96'h440000);
    step(1'b1, 4'h0, '0, '0);

    // source 2 overfilled while stalled
    step(1'b0, 4'b0100, {32'h0, 32'hB1, 32'h0, 32'h0}, 32'h00510000);
    step(1'b0, 4'b0100, {32'h0, 32'hB2, 32'h0, 32'h0}, 32'h00520000);
    @(posedge clk); #1;
    check("src2_full", 96'(src_ready[2]), 96'd0);
    step(1'b0, 4'b0100, {32'h0, 32'hB3, 32'h0, 32'h0}, 32'h00530000);
    step(1'b0, 4'b0000, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, '0, '0);

    // tag 0 is swallowed
    step(1'b1, 4'b0010, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 32'h0);
    @(posedge clk); #1;
    check("tag0_ready", 96'(src_ready[1]), 96'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0, '0, '0);

    // all FIFOs kept full, rotation over four grant cycles
    for (int i = 0; i < 2; i++) begin
      rand_inputs(rd, rt);
      for (int k = 0; k < N; k++) if (rt[8*k +: 8] == 8'd0) rt[8*k +: 8] = 8'hF0 + 8'(k + 4*i);
      step(1'b0, 4'hF, rd, rt);
    end
    for (int i = 0; i < 5; i++) begin
      rand_inputs(rd, rt);
      for (int k = 0; k < N; k++) if (rt[8*k +: 8] == 8'd0) rt[8*k +: 8] = 8'hE0 + 8'(k + 4*i);
      step(1'b1, 4'hF, rd, rt);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, '0, '0);

    // asynchronous reset with results queued and in flight
    step(1'b0, 4'hF, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'h77665544);
    step(1'b1, 4'h0, '0, '0);
    @(posedge clk); #1;
    check("pre_rst_tag", 96'(CDB_tag_serialized), 96'(exp_tag));
    #1 reset = 1'b0;
    #1;
    check("async_rst_tag", 96'(CDB_tag_serialized), 96'd0);
    check("async_rst_data", CDB_data_serialized, 96'd0);
    check("async_rst_ready", 96'(src_ready), 96'hF);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, '0, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(rd, rt);
      step(($urandom_range(0, 3) != 0), 4'($urandom), rd, rt);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 4'h0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of functional-unit result sources (legal 3..8).
REQ-002 SHALL have parameter DEPTH, default 2, per-source result FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  pipeline enable; low = CDB stall.
REQ-006 SHALL have port src_valid  input  N_SRC  bit k = source k presents a result.
REQ-007 SHALL have port src_ready  output  N_SRC  bit k = source k FIFO can accept.
REQ-008 SHALL have port src_data  input  32*N_SRC  source k result at [32k+31:32k].
REQ-009 SHALL have port src_tag  input  8*N_SRC  source k tag at [8k+7:8k].
REQ-010 SHALL have port CDB_data_serialized  output  96  {lane0, lane1, lane2}, lane0 in [95:64].
REQ-011 SHALL have port CDB_tag_serialized  output  24  {lane0, lane1, lane2}, lane0 in [23:16].

Function
REQ-012 Source k transfer SHALL occur on a rising edge where src_valid[k] and src_ready[k] are both high.
REQ-013 src_ready[k] SHALL be high exactly when FIFO k holds fewer than DEPTH entries; it SHALL NOT depend on a same-cycle pop.
REQ-014 A transfer with tag 8'd0 SHALL be accepted and discarded (never enqueued, never broadcast); tag 0 is reserved as "lane idle".
REQ-015 Each cycle with en high, the arbiter SHALL scan FIFOs from rr_ptr upward mod N_SRC and grant up to three non-empty heads, in scan order, to lanes 0, 1, 2.
REQ-016 Granted heads SHALL be popped on that edge and their {data, tag} registered onto their lanes; ungranted lanes SHALL register data 32'd0, tag 8'd0.
REQ-017 rr_ptr SHALL become (index of last granted source + 1) mod N_SRC after any grant and SHALL be unchanged when nothing is granted.
REQ-018 Minimum latency SHALL be 2 edges: result accepted at edge t appears on the CDB after edge t+1 and is held for exactly one cycle.
REQ-019 A source SHALL receive at most one lane per cycle; FIFO order per source SHALL be preserved.
REQ-020 With en low, no grants SHALL occur, rr_ptr SHALL hold, all lanes SHALL register tag 0/data 0, and enqueue SHALL continue per REQ-012/013.
REQ-021 Simultaneous push and pop on one FIFO SHALL both take effect (count unchanged); push on full is impossible by REQ-013.
REQ-022 The same tag SHALL never appear on two lanes in one cycle, given sources issue unique tags.

Reset
REQ-023 While reset is low: all FIFOs empty, rr_ptr = 0, CDB_data_serialized = 96'd0, CDB_tag_serialized = 24'd0, src_ready = all ones.
REQ-024 Reset asserted mid-operation SHALL discard all queued and in-flight results immediately, without waiting for clk.
REQ-025 The first grant after reset deassertion SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 With macro CDB_STATS_EN defined, SHALL add outputs bcast_count (32, total non-idle lanes broadcast) and stall_count (32, cycles with en low and some FIFO non-empty), both wrapping, cleared by reset, counting on the same edge as the event.
REQ-027 Without CDB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset low, drive src_valid=4'hF -> src_ready=4'hF, CDB tags 24'd0 until reset high plus two edges.
REQ-029 Sources 0..3 each push one result (tags 8'h11,8'h22,8'h33,8'h44, data 32'hA0..A3), rr_ptr=0 -> next cycle lanes carry tags 11,22,33; following cycle lane0=44, lanes1-2 idle; rr_ptr ends at 0.
REQ-030 Source 2 pushes 3 results back-to-back with DEPTH=2, no pops (en low) -> src_ready[2] low after second push, third held; no tag on CDB while en low.
REQ-031 Push with tag 8'h00 on source 1, data 32'hDEADBEEF -> accepted (ready stays high), never appears on CDB, FIFO 1 stays empty.
REQ-032 All four FIFOs continuously full, en high for 4 cycles -> grants rotate 0-1-2, 3-0-1, 2-3-0, 1-2-3; each source granted 3 times.
REQ-033 Assert reset asynchronously mid-cycle with 3 queued results -> CDB outputs zero immediately, no queued tag ever broadcast afterwards.
